// File: rtl/uart_pin_mux_pkg.sv
// Shared widths, host command opcodes, controller states and command decode.
package uart_pin_mux_pkg;

  localparam int N_OUT = 16;
  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  localparam logic [2:0] COMM_READ_ENABLE_MASK  = 3'd1;
  localparam logic [2:0] COMM_WRITE_ENABLE_MASK = 3'd2;
  localparam logic [2:0] COMM_READ_PIN_MAP      = 3'd3;
  localparam logic [2:0] COMM_WRITE_PIN_MAP     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_PAYLOAD,
    ST_LOAD,
    ST_TX_BYTE,
    ST_TX_WAIT
  } state_t;

  typedef struct packed {
    logic valid;
    logic write;
    logic is_map;
  } cmd_t;

  // A command byte is only honoured when its upper five bits are clear.
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c = '0;
    if (b[7:3] == 5'd0) begin
      case (b[2:0])
        COMM_READ_ENABLE_MASK:  c = '{valid: 1'b1, write: 1'b0, is_map: 1'b0};
        COMM_WRITE_ENABLE_MASK: c = '{valid: 1'b1, write: 1'b1, is_map: 1'b0};
        COMM_READ_PIN_MAP:      c = '{valid: 1'b1, write: 1'b0, is_map: 1'b1};
        COMM_WRITE_PIN_MAP:     c = '{valid: 1'b1, write: 1'b1, is_map: 1'b1};
        default:                c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_pin_mux_if.sv
// Host serial link and candidate source pins of the pin router.
interface uart_pin_mux_if
  import uart_pin_mux_pkg::*;
  ();
  logic              serial_rx;
  logic              serial_tx;
  logic [N_IN-1:0]   input_pins;

  modport master (output serial_rx, output input_pins, input serial_tx);
  modport slave  (input serial_rx, input input_pins, output serial_tx);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: start-edge detect, mid-bit sampling, stop-bit check.
module uart_byte_rx #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);
  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           valid_q, valid_d;
  logic [1:0]     sync_q;
  logic           rx_s;

  assign rx_s    = sync_q[1];
  assign data_o  = shift_q;
  assign valid_o = valid_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_i};
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // Bit timing: half a bit into the start bit, then one full bit per sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          state_d = RX_IDLE;
          valid_d = rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter: accepts a byte when idle, pulses done after the stop bit.
module uart_byte_tx #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);
  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  logic           busy_q, busy_d;
  logic [9:0]     frame_q, frame_d;
  logic [3:0]     bit_q, bit_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  // Line is forced high whenever nothing is in flight, including during reset.
  assign tx_o   = busy_q ? frame_q[0] : 1'b1;
  assign done_o = done_q;

  // Transmitter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      frame_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Shift out {stop, data, start} one bit every CLK_PER_BIT cycles.
  always_comb begin
    busy_d  = busy_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        frame_d = {1'b1, data_i, 1'b0};
        bit_d   = '0;
        cnt_d   = '0;
      end
    end else if (cnt_q == FULL) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        frame_d = {1'b1, frame_q[9:1]};
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pin_mux.sv
// UART-controlled router: 16 tri-state outputs, each picking one of 4 inputs.
module uart_pin_mux
  import uart_pin_mux_pkg::*;
#(
  parameter int CLK_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_pin_mux_if.slave     bus,
  output wire  [N_OUT-1:0]  output_pins
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_line;
  logic                 tx_done;

  state_t               state_q, state_d;
  logic [N_OUT-1:0]     mask_q, mask_d;
  logic [SEL_W*N_OUT-1:0] map_q, map_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [31:0]          buf_q, buf_d;
  logic                 is_map_q, is_map_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           last_q, last_d;
  cmd_t                 cmd;

  uart_byte_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rx_i    (bus.serial_rx),
    .data_o  (rx_data),
    .valid_o (rx_valid)
  );

  uart_byte_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start_i (tx_start),
    .data_i  (tx_data),
    .tx_o    (tx_line),
    .done_o  (tx_done)
  );

  assign bus.serial_tx = tx_line;
  assign cmd           = decode_cmd(rx_data);
  assign tx_data       = buf_q[7:0];

  // Routing is purely combinational so input changes reach the pins at once.
  for (genvar i = 0; i < N_OUT; i++) begin : g_route
    assign output_pins[i] = mask_q[i] ? bus.input_pins[map_q[SEL_W*i +: SEL_W]] : 1'bz;
  end

  // Controller state, configuration registers and reply buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      map_q    <= '0;
      shadow_q <= '0;
      buf_q    <= '0;
      is_map_q <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      map_q    <= map_d;
      shadow_q <= shadow_d;
      buf_q    <= buf_d;
      is_map_q <= is_map_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  // Command decode, payload staging and little-endian reply sequencing.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    map_d    = map_q;
    shadow_d = shadow_q;
    buf_d    = buf_q;
    is_map_d = is_map_q;
    idx_d    = idx_q;
    last_d   = last_q;
    tx_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && cmd.valid) begin
          is_map_d = cmd.is_map;
          last_d   = cmd.is_map ? 2'd3 : 2'd1;
          idx_d    = '0;
          state_d  = cmd.write ? ST_RX_PAYLOAD : ST_LOAD;
        end
      end
      ST_RX_PAYLOAD: begin
        if (rx_valid) begin
          shadow_d[{idx_q, 3'b000} +: 8] = rx_data;
          if (idx_q == last_q) begin
            // Commit the whole value only once the final byte has arrived.
            if (is_map_q) map_d  = {rx_data, shadow_q[23:0]};
            else          mask_d = {rx_data, shadow_q[7:0]};
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_LOAD: begin
        buf_d   = is_map_q ? map_q : {16'h0000, mask_q};
        idx_d   = '0;
        state_d = ST_TX_BYTE;
      end
      ST_TX_BYTE: begin
        tx_start = 1'b1;
        buf_d    = {8'h00, buf_q[31:8]};
        state_d  = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (tx_done) begin
          if (idx_q == last_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_TX_BYTE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_pin_mux.sv
// Directed bench for uart_pin_mux: serial command/reply traffic and pin routing.
module tb_uart_pin_mux;
  localparam int CPB = 16;

  logic        clk;
  logic        reset;
  wire  [15:0] pins;
  logic        mon_en;
  int          rxq[$];
  int          n_pass;
  int          n_total;

  uart_pin_mux_if bus ();

  uart_pin_mux #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .output_pins (pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.serial_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.serial_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // Collect reply bytes; bit 8 flags a bad stop bit.
  initial begin
    wait (mon_en);
    forever begin
      logic [7:0] b;
      logic       stop;
      @(negedge bus.serial_tx);
      repeat (CPB / 2) @(negedge clk);
      if (bus.serial_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.serial_tx;
        end
        repeat (CPB) @(negedge clk);
        stop = bus.serial_tx;
        rxq.push_back(int'(b) | (stop ? 0 : 256));
      end
    end
  end

  task automatic expect_reply(input string tag, input int n, input logic [31:0] w);
    int t;
    t = 0;
    while (rxq.size() < n && t < 1200) begin
      @(negedge clk);
      t++;
    end
    if (rxq.size() < n) begin
      chk({tag, "_timeout"}, rxq.size(), n);
      rxq.delete();
      return;
    end
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), rxq.pop_front(), {24'h0, w[8*i +: 8]});
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] op, input int n_pay,
                        input logic [31:0] pay, input int n_rep, input logic [31:0] exp);
    send_byte(op);
    for (int i = 0; i < n_pay; i++) send_byte(pay[8*i +: 8]);
    expect_reply(tag, n_rep, exp);
  endtask

  initial begin
    logic [31:0] pm_vals [2];
    logic [31:0] em_vals [2];
    int          t;
    pm_vals[0] = 32'h89ab_cdef;
    pm_vals[1] = 32'haaff_5500;
    em_vals[0] = 32'h0000_abcd;
    em_vals[1] = 32'h0000_aaaa;
    n_pass = 0;
    n_total = 0;
    mon_en = 1'b0;
    bus.serial_rx = 1'b1;
    bus.input_pins = 4'h0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_tx_idle", {31'h0, bus.serial_tx}, 32'h1);
    chk("rst_pins_z", {31'h0, (pins === 16'hzzzz)}, 32'h1);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    do_cmd("rd_pm0_a", 8'h03, 0, 32'h0, 4, 32'h0);
    do_cmd("rd_pm0_b", 8'h03, 0, 32'h0, 4, 32'h0);
    do_cmd("rd_em0_a", 8'h01, 0, 32'h0, 2, 32'h0);
    do_cmd("rd_em0_b", 8'h01, 0, 32'h0, 2, 32'h0);

    for (int k = 0; k < 2; k++) begin
      do_cmd($sformatf("wr_em%0d", k), 8'h02, 2, em_vals[k], 2, em_vals[k]);
      do_cmd($sformatf("rd_em%0d_a", k), 8'h01, 0, 32'h0, 2, em_vals[k]);
      do_cmd($sformatf("rd_em%0d_b", k), 8'h01, 0, 32'h0, 2, em_vals[k]);
    end
    for (int k = 0; k < 2; k++) begin
      do_cmd($sformatf("wr_pm%0d", k), 8'h04, 4, pm_vals[k], 4, pm_vals[k]);
      do_cmd($sformatf("rd_pm%0d_a", k), 8'h03, 0, 32'h0, 4, pm_vals[k]);
      do_cmd($sformatf("rd_pm%0d_b", k), 8'h03, 0, 32'h0, 4, pm_vals[k]);
    end

    // Routing: map all outputs to input 0 and disable them, then enable.
    do_cmd("wr_pm_zero", 8'h04, 4, 32'h0, 4, 32'h0);
    do_cmd("wr_em_zero", 8'h02, 2, 32'h0, 2, 32'h0);
    chk("pins_all_z", {31'h0, (pins === 16'hzzzz)}, 32'h1);
    do_cmd("wr_em_ffff", 8'h02, 2, 32'h0000_ffff, 2, 32'h0000_ffff);
    chk("pins_all_0", {16'h0, pins}, 32'h0000_0000);
    @(negedge clk);
    #2 bus.input_pins = 4'b0001;
    #1 chk("pins_all_1_comb", {16'h0, pins}, 32'h0000_ffff);

    // Partial payload must not disturb routing until the last byte lands.
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("pins_partial", {16'h0, pins}, 32'h0000_ffff);
    send_byte(8'h00);
    send_byte(8'h00);
    expect_reply("wr_pm_01", 4, 32'h0000_0001);
    chk("pins_remap0", {16'h0, pins}, 32'h0000_fffe);

    // Malformed commands are ignored.
    send_byte(8'h07);
    send_byte(8'h21);
    repeat (30 * CPB) @(negedge clk);
    chk("invalid_no_reply", rxq.size(), 0);
    do_cmd("rd_em_after_inv", 8'h01, 0, 32'h0, 2, 32'h0000_ffff);
    do_cmd("rd_pm_after_inv", 8'h03, 0, 32'h0, 4, 32'h0000_0001);

    // Reset in the middle of a reply.
    send_byte(8'h03);
    t = 0;
    while (bus.serial_tx && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reply_started", {31'h0, bus.serial_tx}, 32'h0);
    repeat (3 * CPB) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_tx_high", {31'h0, bus.serial_tx}, 32'h1);
    chk("rst_mid_pins_z", {31'h0, (pins === 16'hzzzz)}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    rxq.delete();
    do_cmd("rd_em_post_rst", 8'h01, 0, 32'h0, 2, 32'h0);
    do_cmd("rd_pm_post_rst", 8'h03, 0, 32'h0, 4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
